// File: rtl/clock_gater.sv
`timescale 1ns/10ps
// Glitch-free clock gate. The enable is captured by a latch that is open only
// while clock_in is low, so clock_out pulses are always whole high phases of clock_in.
module clock_gater (
  input  logic clock_in,
  input  logic resetn,
  input  logic enable,
  input  logic test_enable,
  output logic clock_out
);

  logic en_d;
  logic en_q;

  // Scan/test override shares the functional path through the same latch.
  assign en_d = enable | test_enable;

  // Latch is transparent in the low phase and holds in the high phase.
  // Reset clears it asynchronously.
  always_latch begin
    if (!resetn) begin
      en_q <= 1'b0;
    end else if (!clock_in) begin
      en_q <= en_d;
    end
  end

  // The resetn term ends a pulse the instant reset is asserted,
  // without depending on latch propagation.
  assign clock_out = clock_in & en_q & resetn;

endmodule

// File: tb/tb_clock_gater.sv
`timescale 1ns/10ps
// Bench for clock_gater: random and directed enable activity on a 10 ns clock,
// checked against a phase-level model of which high phases must carry a pulse.
module tb_clock_gater;

  logic clock_in;
  logic resetn;
  logic enable;
  logic test_enable;
  logic clock_out;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  logic exp_pulse = 1'b0;
  realtime t_rise = 0.0;

  clock_gater dut (
    .clock_in    (clock_in),
    .resetn      (resetn),
    .enable      (enable),
    .test_enable (test_enable),
    .clock_out   (clock_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a high phase carries a pulse iff, at the end of the preceding low
  // phase, reset was released and enable|test_enable was 1. Reset kills it.
  always begin
    @(posedge clock_in);
    exp_pulse = resetn && (enable || test_enable);
    #2.25;
    chk("mid_high", clock_out, exp_pulse && resetn);
    @(negedge clock_in);
    #2.25;
    chk("mid_low", clock_out, 1'b0);
  end

  always @(negedge resetn) exp_pulse = 1'b0;

  // Every pulse must be a full 5 ns high phase, unless reset cut it short.
  always @(posedge clock_out) begin
    t_rise = $realtime;
    pulse_cnt++;
  end

  always @(negedge clock_out) begin
    realtime w;
    w = $realtime - t_rise;
    if (resetn) begin
      checks++;
      if (w < 4.99 || w > 5.01) begin
        errors++;
        $display("FAIL pulse_width at %0t: got %0.2f ns expected 5.00 ns", $time, w);
      end
    end
  end

  // Counts clock_out pulses across ncyc input periods.
  task automatic measure(input string name, input int ncyc, input int exp);
    int c0;
    @(negedge clock_in);
    #2;
    c0 = pulse_cnt;
    repeat (ncyc) @(negedge clock_in);
    #2;
    chk_int(name, pulse_cnt - c0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    test_enable = 1'b0;
    #1;
    chk("reset_low", clock_out, 1'b0);

    // Enables asserted while in reset must not leak through.
    #11;
    enable = 1'b1;
    test_enable = 1'b1;
    repeat (2) @(posedge clock_in);
    #1;
    chk("reset_hold_en", clock_out, 1'b0);

    @(negedge clock_in);
    #2;
    resetn = 1'b1;
    enable = 1'b0;
    test_enable = 1'b0;
    measure("freq_off", 20, 0);

    enable = 1'b1;
    measure("freq_enable", 20, 20);
    enable = 1'b0;
    measure("freq_enable_off", 20, 0);

    test_enable = 1'b1;
    measure("freq_test", 20, 20);
    test_enable = 1'b0;
    measure("freq_test_off", 20, 0);

    // test_enable overrides enable=0 even with enable activity around it.
    test_enable = 1'b1;
    enable = 1'b0;
    measure("freq_test_over", 10, 10);
    test_enable = 1'b0;

    // Enable toggled one ns after every rising edge -> every other high phase.
    fork
      begin
        repeat (26) begin
          @(posedge clock_in);
          #1 enable = ~enable;
        end
      end
      measure("freq_half", 20, 10);
    join
    @(negedge clock_in);
    #2 enable = 1'b0;

    // 1000 toggles at random offsets after either edge; never exactly on an edge.
    for (int i = 0; i < 1000; i++) begin
      int off;
      off = $urandom_range(1, 19);
      if (off == 10) off = 11;
      if ($urandom_range(0, 1) == 1) @(posedge clock_in);
      else @(negedge clock_in);
      #(off * 0.5);
      enable = ~enable;
    end
    @(negedge clock_in);
    #2 enable = 1'b0;

    // Reset in the middle of a pulse.
    enable = 1'b1;
    @(posedge clock_in);
    #1.5;
    chk("pre_reset_high", clock_out, 1'b1);
    resetn = 1'b0;
    #0.1;
    chk("reset_immediate", clock_out, 1'b0);
    repeat (2) @(negedge clock_in);
    #2;
    chk("reset_held_low", clock_out, 1'b0);
    resetn = 1'b1;
    @(posedge clock_in);
    #1;
    chk("resume_pulse", clock_out, 1'b1);

    // Release in a high phase: that phase stays low, the next one pulses.
    @(negedge clock_in);
    #2 resetn = 1'b0;
    @(posedge clock_in);
    #1 resetn = 1'b1;
    #1;
    chk("release_high_no_pulse", clock_out, 1'b0);
    @(posedge clock_in);
    #1;
    chk("release_next_pulse", clock_out, 1'b1);

    @(negedge clock_in);
    #2 enable = 1'b0;
    measure("freq_final_off", 5, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
